// File: rtl/rng_ram_mc.sv
// rng_ram_mc: dual-port sample RAM for the TRNG datapath.
// Port A is a dedicated pipelined Wishbone port. Port B's memory port is
// shared between pipelined Wishbone B and a round-robin RNG write arbiter,
// with a token that alternates ownership when both contend.
module rng_ram_mc #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     pA_wb_cyc_i,
  input  logic                     pA_wb_stb_i,
  input  logic [DATA_W/8-1:0]      pA_wb_we_i,
  input  logic [ADDR_W-1:0]        pA_wb_addr_i,
  input  logic [DATA_W-1:0]        pA_wb_data_i,
  output logic                     pA_wb_ack_o,
  output logic                     pA_wb_stall_o,
  output logic [DATA_W-1:0]        pA_wb_data_o,
  input  logic                     pB_wb_cyc_i,
  input  logic                     pB_wb_stb_i,
  input  logic [DATA_W/8-1:0]      pB_wb_we_i,
  input  logic [ADDR_W-1:0]        pB_wb_addr_i,
  input  logic [DATA_W-1:0]        pB_wb_data_i,
  output logic                     pB_wb_ack_o,
  output logic                     pB_wb_stall_o,
  output logic [DATA_W-1:0]        pB_wb_data_o,
  input  logic [N_CH-1:0]          rng_req_i,
  input  logic [N_CH*ADDR_W-1:0]   rng_addr_i,
  input  logic [N_CH*DATA_W-1:0]   rng_data_i,
  output logic [N_CH-1:0]          rng_ack_o,
  output logic [CNT_W-1:0]         rng_wr_count_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  // Which side of the shared port B wins the next contended cycle.
  typedef enum logic {FAV_WB = 1'b0, FAV_RNG = 1'b1} fav_t;

  logic [DATA_W-1:0] mem [DEPTH];

  fav_t              tokB;
  logic [CH_W-1:0]   rr;
  logic [CH_W-1:0]   grantIdx;
  logic [CH_W-1:0]   cand;
  logic              found;
  logic [N_CH-1:0]   eligible;
  logic [N_CH-1:0]   rngAckNext;
  logic [N_CH-1:0]   rngAck;
  logic              rngAny;
  logic              rngGrant;
  logic              acceptA;
  logic              acceptB;
  logic              aInRange;
  logic              bInRange;
  logic [ADDR_W-1:0] bAddr;
  logic [DATA_W-1:0] bData;
  logic [BYTES-1:0]  bWe;
  logic              ackA;
  logic              ackB;
  logic [DATA_W-1:0] rdA;
  logic [DATA_W-1:0] rdB;
  logic [CNT_W-1:0]  wrCount;

  assign pA_wb_stall_o  = rst_i;
  assign pB_wb_stall_o  = rst_i | (rngAny & (tokB == FAV_RNG));
  assign pA_wb_ack_o    = ackA;
  assign pB_wb_ack_o    = ackB;
  assign pA_wb_data_o   = rdA;
  assign pB_wb_data_o   = rdB;
  assign rng_ack_o      = rngAck;
  assign rng_wr_count_o = wrCount;

  assign acceptA = pA_wb_cyc_i & pA_wb_stb_i & ~pA_wb_stall_o;
  assign acceptB = pB_wb_cyc_i & pB_wb_stb_i & ~pB_wb_stall_o;

  // Round-robin pick among requesting channels, skipping the one acked now.
  always_comb begin
    eligible   = rng_req_i & ~rngAck;
    rngAny     = |eligible;
    grantIdx   = '0;
    cand       = '0;
    found      = 1'b0;
    for (int unsigned off = 0; off < N_CH; off++) begin
      cand = CH_W'((32'(rr) + off) % N_CH);
      if (!found && eligible[cand]) begin
        found    = 1'b1;
        grantIdx = cand;
      end
    end
    rngGrant   = ~rst_i & rngAny & ((tokB == FAV_RNG) | ~(pB_wb_cyc_i & pB_wb_stb_i));
    rngAckNext = '0;
    if (rngGrant) rngAckNext[grantIdx] = 1'b1;
  end

  // Port B memory-port mux: RNG grant and WB-B accept are mutually exclusive.
  always_comb begin
    bAddr = pB_wb_addr_i;
    bData = pB_wb_data_i;
    bWe   = acceptB ? pB_wb_we_i : '0;
    if (rngGrant) begin
      bAddr = rng_addr_i[grantIdx*ADDR_W +: ADDR_W];
      bData = rng_data_i[grantIdx*DATA_W +: DATA_W];
      bWe   = '1;
    end
    aInRange = {1'b0, pA_wb_addr_i} < DEPTH_L;
    bInRange = {1'b0, bAddr} < DEPTH_L;
  end

  // RAM writes; port A is applied last so its enabled bytes win a collision.
  always_ff @(posedge clk_i) begin
    if (bInRange) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (bWe[b]) mem[bAddr][b*8 +: 8] <= bData[b*8 +: 8];
      end
    end
    if (acceptA && aInRange) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (pA_wb_we_i[b]) mem[pA_wb_addr_i][b*8 +: 8] <= pA_wb_data_i[b*8 +: 8];
      end
    end
  end

  // Read-first data capture and single-cycle acks for both Wishbone ports.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ackA <= 1'b0;
      ackB <= 1'b0;
      rdA  <= '0;
      rdB  <= '0;
    end else begin
      ackA <= acceptA;
      ackB <= acceptB;
      if (acceptA) rdA <= aInRange ? mem[pA_wb_addr_i] : '0;
      if (acceptB) rdB <= bInRange ? mem[bAddr] : '0;
    end
  end

  // Arbiter state: rr pointer, port B token, RNG ack pulse and write counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr      <= '0;
      tokB    <= FAV_RNG;
      rngAck  <= '0;
      wrCount <= '0;
    end else begin
      rngAck <= rngAckNext;
      if (rngGrant) begin
        rr   <= (grantIdx == CH_W'(N_CH - 1)) ? '0 : grantIdx + 1'b1;
        tokB <= FAV_WB;
        if (wrCount != '1) wrCount <= wrCount + 1'b1;
      end else if (acceptB) begin
        tokB <= FAV_RNG;
      end
    end
  end

endmodule

// File: tb/tb_rng_ram_mc.sv
// tb_rng_ram_mc: directed bench for rng_ram_mc (DEPTH=500 so an out-of-range
// address is representable, CNT_W=4 so counter saturation is reachable).
module tb_rng_ram_mc;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int NC = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          aCyc, aStb, bCyc, bStb;
  logic [3:0]    aWe, bWe;
  logic [AW-1:0] aAddr, bAddr;
  logic [DW-1:0] aDataW, bDataW, aDataR, bDataR;
  logic          aAck, aStall, bAck, bStall;
  logic [NC-1:0] rngReq, rngAck;
  logic [NC*AW-1:0] rngAddr;
  logic [NC*DW-1:0] rngData;
  logic [CW-1:0] rngCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rng_ram_mc #(.DATA_W(DW), .DEPTH(500), .N_CH(NC), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .pA_wb_cyc_i(aCyc), .pA_wb_stb_i(aStb), .pA_wb_we_i(aWe),
    .pA_wb_addr_i(aAddr), .pA_wb_data_i(aDataW),
    .pA_wb_ack_o(aAck), .pA_wb_stall_o(aStall), .pA_wb_data_o(aDataR),
    .pB_wb_cyc_i(bCyc), .pB_wb_stb_i(bStb), .pB_wb_we_i(bWe),
    .pB_wb_addr_i(bAddr), .pB_wb_data_i(bDataW),
    .pB_wb_ack_o(bAck), .pB_wb_stall_o(bStall), .pB_wb_data_o(bDataR),
    .rng_req_i(rngReq), .rng_addr_i(rngAddr), .rng_data_i(rngData),
    .rng_ack_o(rngAck), .rng_wr_count_o(rngCnt)
  );

  typedef struct {
    bit            port;
    logic [3:0]    we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            chkData;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single Wishbone transaction on port A (port=0) or B (port=1).
  task automatic wbOp(input bit port, input logic [3:0] we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input bit chkD, input logic [DW-1:0] exp,
                      input string tag);
    if (!port) begin
      aCyc = 1'b1; aStb = 1'b1; aWe = we; aAddr = addr; aDataW = wd;
    end else begin
      bCyc = 1'b1; bStb = 1'b1; bWe = we; bAddr = addr; bDataW = wd;
    end
    tick();
    aCyc = 1'b0; aStb = 1'b0; aWe = '0;
    bCyc = 1'b0; bStb = 1'b0; bWe = '0;
    chk({tag, " ack"}, port ? bAck : aAck, 1);
    if (chkD) chk({tag, " data"}, port ? bDataR : aDataR, exp);
    tick();
    chk({tag, " ack-low"}, port ? bAck : aAck, 0);
    if (chkD) chk({tag, " hold"}, port ? bDataR : aDataR, exp);
  endtask

  // One RNG write on a channel; waits a bounded number of cycles for its ack.
  task automatic rngWrite(input int ch, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    bit seen;
    logic [NC-1:0] expAck;
    rngAddr[ch*AW +: AW] = addr;
    rngData[ch*DW +: DW] = d;
    rngReq[ch] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 16 && !seen; n++) begin
      tick();
      if (rngAck != '0) seen = 1'b1;
    end
    rngReq[ch] = 1'b0;
    expAck = '0;
    expAck[ch] = 1'b1;
    chk($sformatf("rng ack ch%0d", ch), rngAck, expAck);
    tick();
    chk($sformatf("rng ack pulse ch%0d", ch), rngAck, 0);
  endtask

  initial begin
    logic [7:0] expAckB, expRng, expStall;
    logic [3:0] seqExp [5];
    int nB, nR;
    bit sawStall;

    vecs[0]  = '{0, 4'hF, 9'd100, 32'h1122_3344, 0, 32'h0};
    vecs[1]  = '{0, 4'h0, 9'd100, 32'h0,         1, 32'h1122_3344};
    vecs[2]  = '{1, 4'h5, 9'd100, 32'hAABB_CCDD, 1, 32'h1122_3344};
    vecs[3]  = '{0, 4'h0, 9'd100, 32'h0,         1, 32'h11BB_33DD};
    vecs[4]  = '{1, 4'hF, 9'd499, 32'hCAFE_BABE, 0, 32'h0};
    vecs[5]  = '{0, 4'h0, 9'd499, 32'h0,         1, 32'hCAFE_BABE};
    vecs[6]  = '{0, 4'hF, 9'd500, 32'hDEAD_BEEF, 1, 32'h0};
    vecs[7]  = '{1, 4'h0, 9'd500, 32'h0,         1, 32'h0};
    vecs[8]  = '{1, 4'h0, 9'd499, 32'h0,         1, 32'hCAFE_BABE};
    vecs[9]  = '{0, 4'hA, 9'd100, 32'h5566_7788, 1, 32'h11BB_33DD};
    vecs[10] = '{1, 4'h0, 9'd100, 32'h0,         1, 32'h55BB_77DD};
    vecs[11] = '{0, 4'h0, 9'd3,   32'h0,         1, 32'hA5A5_0003};

    rst = 1'b1;
    aCyc = 0; aStb = 0; aWe = '0; aAddr = '0; aDataW = '0;
    bCyc = 0; bStb = 0; bWe = '0; bAddr = '0; bDataW = '0;
    rngReq = '0; rngAddr = '0; rngData = '0;
    repeat (3) tick();
    chk("rst stallA", aStall, 1);
    chk("rst stallB", bStall, 1);
    rst = 1'b0;
    tick();
    chk("post-rst ackA", aAck, 0);
    chk("post-rst ackB", bAck, 0);
    chk("post-rst dataA", aDataR, 0);
    chk("post-rst dataB", bDataR, 0);
    chk("post-rst rngAck", rngAck, 0);
    chk("post-rst count", rngCnt, 0);
    chk("post-rst stallA", aStall, 0);
    chk("post-rst stallB", bStall, 0);

    // Sequential channel-0 writes, read back on port B.
    for (int i = 0; i < 8; i++) rngWrite(0, 9'(i), 32'hA5A5_0000 + i);
    chk("t1 count", rngCnt, 8);
    for (int i = 0; i < 8; i++)
      wbOp(1, 4'h0, 9'(i), 32'h0, 1, 32'hA5A5_0000 + i, $sformatf("t1 rdB%0d", i));

    // Reset with requests presented: nothing accepted or written, outputs cleared.
    rst = 1'b1;
    aCyc = 1; aStb = 1; aWe = 4'hF; aAddr = 9'd0; aDataW = 32'h0;
    bCyc = 1; bStb = 1; bWe = 4'h0; bAddr = 9'd2;
    rngAddr[1*AW +: AW] = 9'd1; rngData[1*DW +: DW] = 32'h0; rngReq = 4'b0010;
    tick();
    chk("t6 stallA", aStall, 1);
    chk("t6 stallB", bStall, 1);
    chk("t6 ackA", aAck, 0);
    chk("t6 ackB", bAck, 0);
    chk("t6 rngAck", rngAck, 0);
    chk("t6 dataB", bDataR, 0);
    chk("t6 count", rngCnt, 0);
    tick();
    rst = 1'b0;
    aCyc = 0; aStb = 0; aWe = '0; bCyc = 0; bStb = 0; rngReq = '0;
    tick();
    chk("t6 post rngAck", rngAck, 0);
    wbOp(0, 4'h0, 9'd0, 32'h0, 1, 32'hA5A5_0000, "t6 keep0");
    wbOp(0, 4'h0, 9'd1, 32'h0, 1, 32'hA5A5_0001, "t6 keep1");

    // All four channels together: acks in channel order on consecutive cycles.
    for (int c = 0; c < NC; c++) begin
      rngAddr[c*AW +: AW] = 9'(10 + c);
      rngData[c*DW +: DW] = 32'hC0DE_0000 + c;
    end
    seqExp[0] = 4'b0001; seqExp[1] = 4'b0010; seqExp[2] = 4'b0100;
    seqExp[3] = 4'b1000; seqExp[4] = 4'b0000;
    rngReq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t2 ack%0d", k), rngAck, seqExp[k]);
      rngReq = rngReq & ~rngAck;
    end
    rngReq = '0;
    chk("t2 count", rngCnt, 4);
    for (int c = 0; c < NC; c++)
      wbOp(0, 4'h0, 9'(10 + c), 32'h0, 1, 32'hC0DE_0000 + c, $sformatf("t2 rd%0d", c));

    // Channel 1 held while port B streams reads: ownership alternates.
    expAckB = 8'b1010_1010;
    expRng = 8'b0101_0100;
    expStall = 8'b0010_1010;
    nB = 0; nR = 0;
    rngAddr[1*AW +: AW] = 9'd20; rngData[1*DW +: DW] = 32'hBEEF_0000; rngReq = 4'b0010;
    bCyc = 1; bStb = 1; bWe = 4'h0; bAddr = 9'd0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t3 ackB%0d", k), bAck, expAckB[k]);
      chk($sformatf("t3 rngAck%0d", k), rngAck, expRng[k] ? 4'b0010 : 4'b0000);
      if (expAckB[k]) chk($sformatf("t3 dataB%0d", k), bDataR, 32'hA5A5_0000 + (k - 1) / 2);
      if (rngAck[1]) begin
        nR++;
        rngAddr[1*AW +: AW] = 9'(20 + nR);
        rngData[1*DW +: DW] = 32'hBEEF_0000 + nR;
      end
      if (k == 7) begin
        rngReq = '0; bCyc = 0; bStb = 0;
      end else begin
        bAddr = 9'(nB);
      end
      #1;
      chk($sformatf("t3 stall%0d", k), bStall, expStall[k]);
      sawStall = bStall;
      tick();
      if (bCyc && !sawStall) nB++;
    end
    bCyc = 0; bStb = 0;
    chk("t3 count", rngCnt, 7);
    for (int i = 0; i < 3; i++)
      wbOp(0, 4'h0, 9'(20 + i), 32'h0, 1, 32'hBEEF_0000 + i, $sformatf("t3 rd%0d", i));

    // Same-address collision: port A bytes win, remaining bytes from RNG.
    rngAddr[0 +: AW] = 9'd5; rngData[0 +: DW] = 32'hFFFF_FFFF; rngReq = 4'b0001;
    aCyc = 1; aStb = 1; aWe = 4'b0011; aAddr = 9'd5; aDataW = 32'h1234_5678;
    tick();
    aCyc = 0; aStb = 0; aWe = '0; rngReq = '0;
    chk("t4 ackA", aAck, 1);
    chk("t4 old word", aDataR, 32'hA5A5_0005);
    chk("t4 rngAck", rngAck, 4'b0001);
    tick();
    wbOp(1, 4'h0, 9'd5, 32'h0, 1, 32'hFFFF_5678, "t4 merged");
    chk("t4 count", rngCnt, 8);

    // Out-of-range address on port A read and RNG write.
    wbOp(0, 4'h0, 9'd500, 32'h0, 1, 32'h0, "t5 rdA oor");
    rngWrite(2, 9'd500, 32'h0BAD_F00D);
    chk("t5 count", rngCnt, 9);
    wbOp(0, 4'h0, 9'd500, 32'h0, 1, 32'h0, "t5 rdA oor again");

    // Back-to-back port A reads give back-to-back acks.
    aCyc = 1; aStb = 1; aWe = 4'h0; aAddr = 9'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("b2b ack%0d", i), aAck, 1);
      chk($sformatf("b2b data%0d", i), aDataR, 32'hA5A5_0000 + i);
      if (i == 2) begin
        aCyc = 0; aStb = 0;
      end else begin
        aAddr = 9'(i + 1);
      end
    end
    tick();
    chk("b2b ack end", aAck, 0);

    // Counter saturates at 2^CNT_W-1.
    for (int i = 0; i < 6; i++) rngWrite(3, 9'(30 + i), 32'(i));
    chk("sat reach", rngCnt, 15);
    for (int i = 0; i < 2; i++) rngWrite(3, 9'(40 + i), 32'(i));
    chk("sat hold", rngCnt, 15);

    // Table of single Wishbone transactions on both ports.
    for (int i = 0; i < 12; i++)
      wbOp(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
           vecs[i].chkData, vecs[i].rdata, $sformatf("vec%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout act=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
